// File: rtl/urv_div_seq_pkg.sv
// Shared definitions for the uRV divide sequencer:
// funct3 codes for DIV/DIVU/REM/REMU, FSM state encodings, helpers.
package urv_div_seq_pkg;

    localparam logic [2:0] FUNC_DIV  = 3'b100;
    localparam logic [2:0] FUNC_DIVU = 3'b101;
    localparam logic [2:0] FUNC_REM  = 3'b110;
    localparam logic [2:0] FUNC_REMU = 3'b111;

    typedef enum logic [2:0] {
        DIVS_IDLE,
        DIVS_PREP,
        DIVS_ITER,
        DIVS_FIX,
        DIVS_DONE
    } divs_state_e;

    function automatic logic [31:0] neg_if(
        input logic        neg,
        input logic [31:0] val
    );
        return neg ? (~val + 32'd1) : val;
    endfunction

endpackage

// File: rtl/urv_div_step.sv
// One restoring-division step: shift {rem,quo} left, trial-subtract.
// Ports: rem_i/quo_i/dvs_i current state in; rem_o/quo_o next state out.
module urv_div_step (
    input  logic [32:0] rem_i,
    input  logic [31:0] quo_i,
    input  logic [31:0] dvs_i,
    output logic [32:0] rem_o,
    output logic [31:0] quo_o
);

    logic [33:0] rem_sh;
    logic [33:0] diff;

    always_comb begin
        rem_sh = {rem_i, quo_i[31]};
        diff   = rem_sh - {2'b00, dvs_i};
        if (!diff[33]) begin
            rem_o = diff[32:0];
            quo_o = {quo_i[30:0], 1'b1};
        end else begin
            rem_o = rem_sh[32:0];
            quo_o = {quo_i[30:0], 1'b0};
        end
    end

endmodule

// File: rtl/urv_div_seq.sv
// Multi-cycle DIV/DIVU/REM/REMU sequencer with pipeline stall request.
// Ports: x_* execute-stage inputs, x_stall_req_o, w_div_result_o/done_o.
module urv_div_seq
    import urv_div_seq_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        x_valid_i,
    input  logic        x_is_div_i,
    input  logic [2:0]  x_fun_i,
    input  logic [31:0] x_rs1_i,
    input  logic [31:0] x_rs2_i,
    input  logic        x_kill_i,
    input  logic        x_stall_i,
    output logic        x_stall_req_o,
    output logic [31:0] w_div_result_o,
    output logic        w_div_done_o
);

    divs_state_e state_q, state_d;
    logic [2:0]  fun_q, fun_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] dvs_q, dvs_d;
    logic [32:0] rem_q, rem_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        q_neg_q, q_neg_d;
    logic        r_neg_q, r_neg_d;
    logic [31:0] result_q, result_d;
    logic        done_q, done_d;

    logic        start;
    logic        in_signed;
    logic        in_rem;
    logic        by_zero;
    logic        ovf;
    logic        op_signed;
    logic        op_rem;
    logic [32:0] step_rem;
    logic [31:0] step_quo;

    urv_div_step u_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .dvs_i (dvs_q),
        .rem_o (step_rem),
        .quo_o (step_quo)
    );

    always_comb begin
        start = (state_q == DIVS_IDLE) & x_valid_i
              & x_is_div_i & ~x_kill_i;
        in_signed = (x_fun_i == FUNC_DIV) | (x_fun_i == FUNC_REM);
        in_rem    = (x_fun_i == FUNC_REM) | (x_fun_i == FUNC_REMU);
        by_zero   = (x_rs2_i == 32'd0);
        ovf       = in_signed & (x_rs1_i == 32'h8000_0000)
                  & (x_rs2_i == 32'hFFFF_FFFF);
        op_signed = (fun_q == FUNC_DIV) | (fun_q == FUNC_REM);
        op_rem    = (fun_q == FUNC_REM) | (fun_q == FUNC_REMU);
    end

    assign x_stall_req_o = start
                         | (state_q == DIVS_PREP)
                         | (state_q == DIVS_ITER)
                         | (state_q == DIVS_FIX);

    always_comb begin
        state_d  = state_q;
        fun_d    = fun_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        rem_d    = rem_q;
        cnt_d    = cnt_q;
        q_neg_d  = q_neg_q;
        r_neg_d  = r_neg_q;
        result_d = result_q;
        done_d   = 1'b0;

        unique case (state_q)
            DIVS_IDLE: begin
                if (start) begin
                    if (by_zero) begin
                        result_d = in_rem ? x_rs1_i : 32'hFFFF_FFFF;
                        done_d   = 1'b1;
                        state_d  = DIVS_DONE;
                    end else if (ovf) begin
                        result_d = in_rem ? 32'd0 : 32'h8000_0000;
                        done_d   = 1'b1;
                        state_d  = DIVS_DONE;
                    end else begin
                        fun_d   = x_fun_i;
                        quo_d   = x_rs1_i;
                        dvs_d   = x_rs2_i;
                        state_d = DIVS_PREP;
                    end
                end
            end
            DIVS_PREP: begin
                if (op_signed) begin
                    quo_d = neg_if(quo_q[31], quo_q);
                    dvs_d = neg_if(dvs_q[31], dvs_q);
                end
                q_neg_d = op_signed & (quo_q[31] ^ dvs_q[31]);
                r_neg_d = op_signed & quo_q[31];
                rem_d   = 33'd0;
                cnt_d   = 5'd0;
                state_d = DIVS_ITER;
            end
            DIVS_ITER: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = DIVS_FIX;
                end
            end
            DIVS_FIX: begin
                result_d = op_rem ? neg_if(r_neg_q, rem_q[31:0])
                                  : neg_if(q_neg_q, quo_q);
                done_d   = 1'b1;
                state_d  = DIVS_DONE;
            end
            DIVS_DONE: begin
                if (x_stall_i) begin
                    done_d = 1'b1;
                end else begin
                    state_d = DIVS_IDLE;
                end
            end
            default: begin
                state_d = DIVS_IDLE;
            end
        endcase

        // A flush abandons the operation but keeps the last result.
        if (x_kill_i) begin
            state_d  = DIVS_IDLE;
            done_d   = 1'b0;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= DIVS_IDLE;
            fun_q    <= 3'd0;
            quo_q    <= 32'd0;
            dvs_q    <= 32'd0;
            rem_q    <= 33'd0;
            cnt_q    <= 5'd0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            result_q <= 32'd0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            fun_q    <= fun_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            rem_q    <= rem_d;
            cnt_q    <= cnt_d;
            q_neg_q  <= q_neg_d;
            r_neg_q  <= r_neg_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign w_div_result_o = result_q;
    assign w_div_done_o   = done_q;

endmodule

// File: tb/tb_urv_div_seq.sv
// Directed bench for urv_div_seq: results, stall length,
// done latency, kill, downstream stall and reset.
module tb_urv_div_seq;
    import urv_div_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        x_valid_i = 1'b0;
    logic        x_is_div_i = 1'b0;
    logic [2:0]  x_fun_i = 3'd0;
    logic [31:0] x_rs1_i = 32'd0;
    logic [31:0] x_rs2_i = 32'd0;
    logic        x_kill_i = 1'b0;
    logic        x_stall_i = 1'b0;
    logic        x_stall_req_o;
    logic [31:0] w_div_result_o;
    logic        w_div_done_o;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    urv_div_seq dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .x_valid_i      (x_valid_i),
        .x_is_div_i     (x_is_div_i),
        .x_fun_i        (x_fun_i),
        .x_rs1_i        (x_rs1_i),
        .x_rs2_i        (x_rs2_i),
        .x_kill_i       (x_kill_i),
        .x_stall_i      (x_stall_i),
        .x_stall_req_o  (x_stall_req_o),
        .w_div_result_o (w_div_result_o),
        .w_div_done_o   (w_div_done_o)
    );

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0]  f,
                         input logic [31:0] a,
                         input logic [31:0] b);
        x_valid_i  = 1'b1;
        x_is_div_i = 1'b1;
        x_fun_i    = f;
        x_rs1_i    = a;
        x_rs2_i    = b;
    endtask

    task automatic drop();
        x_valid_i  = 1'b0;
        x_is_div_i = 1'b0;
        x_rs1_i    = 32'hDEAD_BEEF;
        x_rs2_i    = 32'h0BAD_F00D;
    endtask

    // Called at posedge+1 with the DUT idle; returns idle.
    task automatic run_op(input string       tag,
                          input logic [2:0]  f,
                          input logic [31:0] a,
                          input logic [31:0] b,
                          input logic [31:0] exp,
                          input int          exp_stall,
                          input int          hold);
        int  n;
        int  lat;
        int  nd;
        bit  seen;
        bit  stable;
        n = 0;
        lat = 0;
        seen = 0;
        issue(f, a, b);
        #1;
        if (x_stall_req_o) n++;
        step();
        drop();
        for (int c = 2; c <= 80 && !seen; c++) begin
            if (w_div_done_o) begin
                seen = 1;
                lat = c;
            end else begin
                if (x_stall_req_o) n++;
                step();
            end
        end
        check({tag, "_seen"}, 32'(seen), 32'd1);
        check({tag, "_res"}, w_div_result_o, exp);
        check({tag, "_stall"}, n, exp_stall);
        check({tag, "_lat"}, lat, exp_stall + 1);
        nd = 0;
        stable = 1;
        while (w_div_done_o && nd < 10) begin
            nd++;
            if (w_div_result_o !== exp) stable = 0;
            x_stall_i = (nd <= hold);
            step();
        end
        x_stall_i = 1'b0;
        check({tag, "_dlen"}, nd, hold + 1);
        check({tag, "_stable"}, 32'(stable), 32'd1);
    endtask

    initial begin
        bit quiet;
        repeat (3) step();
        rst = 1'b0;
        check("rst_done", 32'(w_div_done_o), 32'd0);
        check("rst_res", w_div_result_o, 32'd0);
        check("rst_stall", 32'(x_stall_req_o), 32'd0);

        run_op("divu_100_7", FUNC_DIVU, 32'd100, 32'd7, 32'd14, 35, 0);
        run_op("remu_100_7", FUNC_REMU, 32'd100, 32'd7, 32'd2, 35, 0);
        run_op("div_m7_2", FUNC_DIV, 32'hFFFF_FFF9, 32'd2,
               32'hFFFF_FFFD, 35, 0);
        run_op("rem_m7_2", FUNC_REM, 32'hFFFF_FFF9, 32'd2,
               32'hFFFF_FFFF, 35, 0);
        run_op("div_7_m2", FUNC_DIV, 32'd7, 32'hFFFF_FFFE,
               32'hFFFF_FFFD, 35, 0);
        run_op("rem_7_m2", FUNC_REM, 32'd7, 32'hFFFF_FFFE,
               32'd1, 35, 0);
        run_op("div_min_2", FUNC_DIV, 32'h8000_0000, 32'd2,
               32'hC000_0000, 35, 0);
        run_op("divu_max_1", FUNC_DIVU, 32'hFFFF_FFFF, 32'd1,
               32'hFFFF_FFFF, 35, 0);
        run_op("divu_min_m1", FUNC_DIVU, 32'h8000_0000, 32'hFFFF_FFFF,
               32'd0, 35, 0);
        run_op("divu_5_0", FUNC_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0);
        run_op("remu_5_0", FUNC_REMU, 32'd5, 32'd0, 32'd5, 1, 0);
        run_op("div_5_0", FUNC_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0);
        run_op("div_ovf", FUNC_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
               32'h8000_0000, 1, 0);
        run_op("rem_ovf", FUNC_REM, 32'h8000_0000, 32'hFFFF_FFFF,
               32'd0, 1, 0);
        run_op("divu_100_7b", FUNC_DIVU, 32'd100, 32'd7, 32'd14, 35, 0);

        // Kill at ITER step 10 (13th cycle after acceptance).
        issue(FUNC_DIVU, 32'd1000, 32'd3);
        step();
        drop();
        repeat (11) step();
        check("kill_pre_stall", 32'(x_stall_req_o), 32'd1);
        x_kill_i = 1'b1;
        step();
        x_kill_i = 1'b0;
        check("kill_stall", 32'(x_stall_req_o), 32'd0);
        check("kill_done", 32'(w_div_done_o), 32'd0);
        check("kill_res", w_div_result_o, 32'd14);
        quiet = 1;
        for (int i = 0; i < 40; i++) begin
            if (w_div_done_o || x_stall_req_o) quiet = 0;
            step();
        end
        check("kill_quiet", 32'(quiet), 32'd1);
        run_op("divu_9_3", FUNC_DIVU, 32'd9, 32'd3, 32'd3, 35, 0);

        // Downstream stall holds DONE three extra cycles.
        run_op("hold_div", FUNC_DIV, 32'hFFFF_FF9C, 32'd7,
               32'hFFFF_FFF2, 35, 3);
        check("hold_idle_done", 32'(w_div_done_o), 32'd0);

        // Accept while the downstream stall is already high.
        x_stall_i = 1'b1;
        issue(FUNC_REMU, 32'd50, 32'd8);
        step();
        drop();
        x_stall_i = 1'b0;
        repeat (34) step();
        check("acc_stall_done", 32'(w_div_done_o), 32'd1);
        check("acc_stall_res", w_div_result_o, 32'd2);
        step();

        // Reset in the middle of ITER.
        issue(FUNC_DIVU, 32'd77, 32'd5);
        step();
        drop();
        repeat (6) step();
        rst = 1'b1;
        step();
        check("iter_rst_done", 32'(w_div_done_o), 32'd0);
        check("iter_rst_res", w_div_result_o, 32'd0);
        check("iter_rst_stall", 32'(x_stall_req_o), 32'd0);
        rst = 1'b0;
        repeat (40) step();
        check("iter_rst_quiet", 32'(w_div_done_o), 32'd0);
        run_op("post_rst", FUNC_REMU, 32'd77, 32'd5, 32'd2, 35, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/urv_div_seq.md
# urv_div_seq

Multi-cycle divide sequencer for the uRV execute stage. Decode flags DIV/DIVU/REM/REMU through `x_is_div`, and this block services those instructions. It owns a single 32-iteration restoring divider, stalls the pipeline while the divider runs, and handles the RISC-V special cases: divide-by-zero and signed overflow. Its result feeds the writeback mux under the RD_SOURCE_DIVIDE source.

## Interface
- No parameters. Width is fixed at 32.
- `clk_i` in 1: core clock.
- `rst_i` in 1: reset, synchronous and active-high.
- `x_valid_i` in 1: the execute-stage instruction is valid.
- `x_is_div_i` in 1: the instruction is DIV/DIVU/REM/REMU.
- `x_fun_i` in 3: funct3. 100=DIV, 101=DIVU, 110=REM, 111=REMU.
- `x_rs1_i` in 32: dividend.
- `x_rs2_i` in 32: divisor.
- `x_kill_i` in 1: flush. Aborts any operation in flight.
- `x_stall_i` in 1: downstream stall. Holds the DONE state.
- `x_stall_req_o` out 1: stall request to the pipeline control. Combinational.
- `w_div_result_o` out 32: quotient or remainder. Registered.
- `w_div_done_o` out 1: result valid. Registered.

## Operation
- States: IDLE, PREP, ITER, FIX, DONE.
- **Start condition:** `start = IDLE & x_valid_i & x_is_div_i & !x_kill_i`.
- **IDLE**
  - On start with `x_rs2_i==0`: go to DONE. Result is 0xFFFFFFFF for DIV/DIVU and `x_rs1_i` for REM/REMU.
  - On start with a signed op, `x_rs1_i==0x80000000` and `x_rs2_i==0xFFFFFFFF`: go to DONE. Result is 0x80000000 for DIV and 0 for REM.
  - Otherwise on start: latch the operands and funct3, then go to PREP.
- **PREP**
  - For signed ops, replace each operand with its absolute value.
  - Record `q_neg = sign(rs1)^sign(rs2)` and `r_neg = sign(rs1)`.
  - Clear the 33-bit partial remainder and the 5-bit counter. Go to ITER.
- **ITER** (one step per cycle)
  - `{rem,quo} <<= 1`, shifting in the dividend MSB.
  - Compute `t = rem - divisor` at 33 bits. If `t >= 0`, set `rem = t` and `quo[0] = 1`.
  - The counter increments each step. At count 31, go to FIX.
- **FIX**
  - Negate the quotient if `q_neg`, or the remainder if `r_neg` (signed ops only).
  - Select the quotient or the remainder by `fun[1]`. Register it into `w_div_result_o`. Go to DONE.
- **DONE**
  - `w_div_done_o=1`. The state holds while `x_stall_i=1`.
  - When `x_stall_i=0`, go to IDLE.
- `x_kill_i` in any state forces IDLE on the next edge, with no done pulse and the result unchanged. `rst_i` does the same and also clears the outputs.
- A new operation is accepted only in IDLE. DONE never chains directly into a start.
- A start accepted while `x_stall_i=1` proceeds normally. Operands are latched, so the inputs may change after acceptance.

## Timing
- `x_stall_req_o = start | PREP | ITER | FIX`. It is low in DONE and in IDLE without a start.
- **Normal operation**
  - Stall is high for 35 cycles: the accept cycle, PREP, 32 ITER cycles and FIX.
  - `w_div_done_o` rises on the 36th cycle after acceptance.
- **Special cases:** stall is high for 1 cycle and done rises on the next cycle.
- `w_div_done_o` is high for exactly one cycle unless `x_stall_i` extends DONE. The result is stable for the whole time done is high.
- Reset values: state=IDLE, `w_div_done_o=0`, `w_div_result_o=0`, counter=0, `x_stall_req_o=0` (given IDLE with no start).

## Structure
- Add the FUNC_DIV/DIVU/REM/REMU codes and the state encodings DIVS_IDLE..DIVS_DONE to the shared `kmkz_defs.v`.
- Put the 33-bit compare/subtract/shift step in one combinational sub-module, `urv_div_step`. The FSM, counter and sign fix-up stay in `urv_div_seq`.

## Test plan
- **DIVU normal:** DIVU 100/7 → `x_stall_req_o` high for 35 cycles, then done with 14. REMU 100/7 → 2.
- **Signed rounding:** DIV −7/2 → 0xFFFFFFFD. REM −7/2 → 0xFFFFFFFF (−1). DIV 7/−2 → 0xFFFFFFFD.
- **Divide-by-zero:** DIVU 5/0 → stall 1 cycle, done next cycle with 0xFFFFFFFF. REMU 5/0 → 5.
- **Overflow:** DIV 0x80000000/0xFFFFFFFF → 0x80000000 after a 1-cycle stall. REM on the same operands → 0.
- **Kill mid-operation:** assert `x_kill_i` at ITER step 10 → IDLE next cycle, with no done pulse and stall dropped. A following DIVU 9/3 returns 3 with normal latency.
- **Downstream stall:** hold `x_stall_i` for 3 cycles during DONE → done and result held for 4 cycles, then IDLE. Apply `rst_i` during ITER → IDLE with outputs zero.
